// File: rtl/fir_mac_seq.sv
// Sequenced multi-channel FIR multiply-accumulate engine: one shared coefficient
// stream from a synchronous ROM, per-channel accumulators, saturated scaled output.
module fir_mac_seq #(
    parameter int NCH       = 2,
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int ACCW      = 40,
    parameter int NTAPS     = 1021,
    parameter int AW        = 10,
    parameter int OUT_SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sequencing,
    input  logic [NCH*DW-1:0]    smpl_in,
    output logic [AW-1:0]        coeff_addr,
    input  logic signed [CW-1:0] coeff,
    output logic [NCH*DW-1:0]    smpl_out,
    output logic [NCH-1:0]       sat,
    output logic                 valid,
    output logic                 busy
);

    localparam int TCW = $clog2(NTAPS + 1);
    localparam logic [TCW-1:0] TAP_MAX  = TCW'(NTAPS);
    localparam logic [AW-1:0]  ADDR_MAX = AW'(NTAPS);
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state, state_nxt;

    logic [TCW-1:0]               tap_cnt;
    logic signed [ACCW-1:0]       acc     [NCH];
    logic signed [DW+CW-1:0]      prod    [NCH];
    logic signed [ACCW-1:0]       acc_sum [NCH];
    logic signed [ACCW-1:0]       shifted [NCH];
    logic [DW-1:0]                res     [NCH];
    logic [NCH-1:0]               clip;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:    if (sequencing) state_nxt = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (!sequencing) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-channel product/accumulate and the saturating output stage.
    always_comb begin
        clip = '0;
        for (int k = 0; k < NCH; k++) begin
            prod[k]    = $signed(smpl_in[k*DW +: DW]) * coeff;
            acc_sum[k] = acc[k] + ACCW'(prod[k]);
            shifted[k] = acc[k] >>> OUT_SHIFT;
            res[k]     = shifted[k][DW-1:0];
            if (shifted[k] > MAXV) begin
                res[k]  = MAXV[DW-1:0];
                clip[k] = 1'b1;
            end else if (shifted[k] < MINV) begin
                res[k]  = MINV[DW-1:0];
                clip[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coeff_addr <= '0;
            tap_cnt    <= '0;
            smpl_out   <= '0;
            sat        <= '0;
            valid      <= 1'b0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    coeff_addr <= '0;
                    if (sequencing) begin
                        coeff_addr <= AW'(1);
                        tap_cnt    <= '0;
                        for (int k = 0; k < NCH; k++) acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (sequencing) begin
                        if (tap_cnt < TAP_MAX) begin
                            tap_cnt <= tap_cnt + TCW'(1);
                            for (int k = 0; k < NCH; k++) acc[k] <= acc_sum[k];
                            if (coeff_addr != ADDR_MAX) coeff_addr <= coeff_addr + AW'(1);
                        end
                    end else begin
                        for (int k = 0; k < NCH; k++) smpl_out[k*DW +: DW] <= res[k];
                        sat        <= clip;
                        valid      <= 1'b1;
                        coeff_addr <= '0;
                    end
                end
                default: coeff_addr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed testbench for fir_mac_seq with a 4-tap configuration and a behavioural
// one-cycle-latency coefficient ROM.
module tb_fir_mac_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sequencing;
    logic [31:0]        smpl_in;
    logic [2:0]         coeff_addr;
    logic signed [15:0] coeff;
    logic [31:0]        smpl_out;
    logic [1:0]         sat;
    logic               valid;
    logic               busy;

    logic [15:0] rom [0:7];

    int tests_run    = 0;
    int tests_failed = 0;

    fir_mac_seq #(
        .NCH(2), .DW(16), .CW(16), .ACCW(40), .NTAPS(4), .AW(3), .OUT_SHIFT(15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .smpl_out   (smpl_out),
        .sat        (sat),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coeff <= rom[coeff_addr];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic seq, input logic [15:0] c0, input logic [15:0] c1);
        sequencing = seq;
        smpl_in    = {c1, c0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic loadRom(input logic [15:0] c0, c1, c2, c3);
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
        for (int i = 4; i < 8; i++) rom[i] = 16'h7777;
    endtask

    // Prime cycle plus (high_cycles-1) ACCUM cycles, then the single low cycle.
    task automatic runFrame(input int high_cycles, input logic [15:0] c0, input logic [15:0] c1);
        for (int j = 0; j < high_cycles; j++) begin
            applyStimulus(1'b1, c0, c1);
            checkOutput("addr_run", {29'd0, coeff_addr}, (j < 4) ? j : 4);
            if (j > 0) checkOutput("valid_in_frame", {31'd0, valid}, 32'd0);
            tick();
        end
        applyStimulus(1'b0, 16'h1234, 16'h5678);
        checkOutput("addr_end", {29'd0, coeff_addr}, (high_cycles < 4) ? high_cycles : 4);
        checkOutput("busy_end", {31'd0, busy}, 32'd1);
        tick();
    endtask

    initial begin
        loadRom(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            sequencing = 1'($urandom_range(0, 1));
            smpl_in    = $urandom;
            tick();
            checkOutput("rst_smpl_out", smpl_out, 32'd0);
            checkOutput("rst_sat", {30'd0, sat}, 32'd0);
            checkOutput("rst_valid", {31'd0, valid}, 32'd0);
            checkOutput("rst_addr", {29'd0, coeff_addr}, 32'd0);
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'h4000, 16'hC000);
            tick();
            checkOutput("idle_valid", {31'd0, valid}, 32'd0);
        end

        // Basic frame
        runFrame(5, 16'h4000, 16'hC000);
        checkOutput("basic_valid", {31'd0, valid}, 32'd1);
        checkOutput("basic_out", smpl_out, 32'hC400_3C00);
        checkOutput("basic_sat", {30'd0, sat}, 32'd0);
        checkOutput("basic_addr0", {29'd0, coeff_addr}, 32'd0);
        checkOutput("basic_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("basic_pulse", {31'd0, valid}, 32'd0);
        checkOutput("basic_hold", smpl_out, 32'hC400_3C00);

        // Tap limit: extra high cycles must not accumulate ROM[4..]
        runFrame(10, 16'h4000, 16'hC000);
        checkOutput("limit_valid", {31'd0, valid}, 32'd1);
        checkOutput("limit_out", smpl_out, 32'hC400_3C00);
        checkOutput("limit_sat", {30'd0, sat}, 32'd0);
        tick();

        // Saturation in both directions
        loadRom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        runFrame(5, 16'h7FFF, 16'h8000);
        checkOutput("sat_valid", {31'd0, valid}, 32'd1);
        checkOutput("sat_out", smpl_out, 32'h8000_7FFF);
        checkOutput("sat_flags", {30'd0, sat}, 32'd3);
        tick();
        checkOutput("sat_hold", {30'd0, sat}, 32'd3);

        // Back-to-back frames followed by a zero-tap frame
        loadRom(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        runFrame(5, 16'h4000, 16'hC000);
        checkOutput("b2b1_valid", {31'd0, valid}, 32'd1);
        checkOutput("b2b1_out", smpl_out, 32'hC400_3C00);
        runFrame(5, 16'h0000, 16'hC000);
        checkOutput("b2b2_valid", {31'd0, valid}, 32'd1);
        checkOutput("b2b2_out", smpl_out, 32'hC400_0000);
        checkOutput("b2b2_sat", {30'd0, sat}, 32'd0);
        runFrame(1, 16'h4000, 16'hC000);
        checkOutput("zero_valid", {31'd0, valid}, 32'd1);
        checkOutput("zero_out", smpl_out, 32'd0);
        checkOutput("zero_sat", {30'd0, sat}, 32'd0);
        tick();
        checkOutput("zero_pulse", {31'd0, valid}, 32'd0);

        // Mid-frame reset after a frame that left nonzero outputs
        runFrame(5, 16'h4000, 16'hC000);
        checkOutput("pre_rst_out", smpl_out, 32'hC400_3C00);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 16'h4000, 16'hC000);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h4000, 16'hC000);
        checkOutput("midrst_out", smpl_out, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_addr", {29'd0, coeff_addr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
            tick();
        end
        checkOutput("midrst_out_hold", smpl_out, 32'd0);
        runFrame(5, 16'h4000, 16'hC000);
        checkOutput("post_rst_valid", {31'd0, valid}, 32'd1);
        checkOutput("post_rst_out", smpl_out, 32'hC400_3C00);
        checkOutput("post_rst_sat", {30'd0, sat}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, multi-channel, sequenced FIR multiply-accumulate engine. It is the generalised successor to the fixed two-channel, 16-bit FIR banks in the audio filter chain. An upstream sample queue streams one sample per channel per cycle while `sequencing` is high. The block pairs each sample with a coefficient from an external synchronous ROM and accumulates per channel. When the frame ends, it outputs a saturated, scaled result with a one-cycle `valid` strobe. New over the previous generation: channel count and widths are parameters, there is a tap-count limit, output saturation with flags, an explicit result strobe, and synchronous reset.

## Interface
Parameters:
- `NCH`, 2: number of channels sharing one coefficient stream
- `DW`, 16: signed sample and output width
- `CW`, 16: signed coefficient width
- `ACCW`, 40: accumulator width; must be ≥ `DW`+`CW`
- `NTAPS`, 1021: maximum products accumulated per frame
- `AW`, 10: ROM address width; 2^`AW` > `NTAPS`
- `OUT_SHIFT`, 15: arithmetic right shift applied to the accumulator at output

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset is synchronous and active-low
- `sequencing`  in  1  high while the queue presents a valid sample every cycle
- `smpl_in`  in  `NCH`*`DW`  signed samples; channel k at [k*`DW` +: `DW`]
- `coeff_addr`  out  `AW`  registered ROM address
- `coeff`  in  `CW`  signed ROM data; equals ROM[`coeff_addr`] of the previous cycle
- `smpl_out`  out  `NCH`*`DW`  saturated filter results, held until the next frame result
- `sat`  out  `NCH`  per-channel flag; 1 = the held `smpl_out` channel was clipped
- `valid`  out  1  one-cycle pulse when `smpl_out`/`sat` update
- `busy`  out  1  high in ACCUM

## Operation
- States: IDLE, ACCUM.
- IDLE:
  - `coeff_addr` = 0; accumulators hold.
  - If `sequencing`=1 this is the prime cycle: clear all accumulators and tap counter, set `coeff_addr` to 1, go to ACCUM.
  - The sample present in the prime cycle is discarded.
- ACCUM with `sequencing`=1 and tap_cnt < `NTAPS`:
  - For each channel, acc[k] += sext(`coeff` * smpl_in[k]).
  - The full-precision signed product is `DW`+`CW` bits, sign-extended to `ACCW`.
  - tap_cnt++.
  - `coeff_addr`++, but it holds once it reaches `NTAPS`.
  - The i-th ACCUM cycle (i from 0) therefore uses ROM[i].
- ACCUM with `sequencing`=1 and tap_cnt = `NTAPS`: no accumulation, no address change, stay in ACCUM.
- ACCUM with `sequencing`=0 (frame end):
  - Per channel, r = acc[k] >>> `OUT_SHIFT`.
  - Saturate r to signed `DW`, giving [-2^(`DW`-1), 2^(`DW`-1)-1]. `sat`[k] = 1 iff clipped.
  - Register `smpl_out`, `sat`, and `valid`=1 at this edge.
  - Go to IDLE; `coeff_addr` returns to 0.
- Accumulator overflow within `ACCW` wraps (two's complement). Sizing `ACCW` to avoid this is the integrator's responsibility.
- Zero-tap frame (prime cycle, then `sequencing`=0): `smpl_out`=0, `sat`=0, `valid` pulses.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `coeff_addr`=0, `smpl_out`=0, `sat`=0, `valid`=0, `busy`=0.
  - Accumulators and tap_cnt = 0.
  - Applies mid-frame: the frame is aborted with no `valid`.
- ROM latency: exactly 1 cycle.
- Frame of N products: `sequencing` high for N+1 cycles. `valid` is high in the cycle after `sequencing` first samples low in ACCUM.
- `valid` is a single-cycle pulse; it is never high two consecutive cycles.
- `smpl_out` and `sat` change only with `valid`.
- Back-to-back frames:
  - `sequencing` low for one cycle, then high again.
  - The low cycle ends frame 1.
  - The next cycle is IDLE with `sequencing`=1, which is the prime cycle of frame 2, and `valid` for frame 1 is high in that same cycle.
  - Frame 2 results are unaffected by frame 1.
- `busy` is combinational from state.

## Test plan
- Reset: drive random inputs with `rst_n`=0 for 3 cycles. All outputs must be 0 and `coeff_addr`=0. Then hold `sequencing`=0 for 5 cycles; `valid` must stay 0.
- Basic frame:
  - Setup: `NTAPS`=4; ROM={0x4000,0x2000,0x1000,0x0800}; ch0=0x4000, ch1=0xC000.
  - Stimulus: `sequencing` high 5 cycles, then low.
  - Expected: `coeff_addr` runs 0,1,2,3,4 then 0. `valid` pulses once with ch0=0x3C00, ch1=0xC400, `sat`=00.
- Saturation:
  - Positive: ROM all 0x7FFF, ch0=0x7FFF, 4 taps → ch0=0x7FFF, `sat`[0]=1.
  - Negative: ch1=0x8000 → ch1=0x8000, `sat`[1]=1.
- Tap limit: repeat the basic frame but hold `sequencing` high 10 cycles. Results must be identical to the basic frame, with `coeff_addr` holding at 4 until the frame ends.
- Back-to-back and zero-tap:
  - Basic frame, one low cycle, then an immediate second frame with ch0=0. `valid` must pulse for each frame, with results 0x3C00 then 0x0000.
  - Then 1-cycle `sequencing` (prime only) → `valid` with `smpl_out`=0.
- Reset mid-frame: assert `rst_n`=0 during ACCUM cycle 2 of the basic frame. No `valid` may appear and `smpl_out` must read 0. A following full frame must produce 0x3C00/0xC400.
